// File: rtl/sub_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-serial subtractor controller.
package sub_seq_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sub_seq_state_t;

  localparam int   NIB_W         = 4;
  localparam logic BIN_NO_BORROW = 1'b1;

endpackage

// File: rtl/sub_4bit.sv
// 4-bit borrow-lookahead subtract slice: dout = din1 - din2 - ~bin.
// bin=1 means no borrow in; bout=1 means borrow out.
module sub_4bit (
  input  logic [3:0] din1,
  input  logic [3:0] din2,
  input  logic       bin,
  output logic [3:0] dout,
  output logic       bout,
  output logic       pg,
  output logic       gg
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // g: this bit borrows on its own; p: an incoming borrow passes through
  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign g[gi]    = ~din1[gi] & din2[gi];
    assign p[gi]    = ~(din1[gi] ^ din2[gi]);
    assign dout[gi] = din1[gi] ^ din2[gi] ^ c[gi];
  end

  assign c[0] = ~bin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pg   = &p;
  assign c[4] = gg | (pg & c[0]);
  assign bout = c[4];

endmodule

// File: rtl/sub_seq_ctrl.sv
// Nibble-serial WIDTH-bit subtractor: one shared 4-bit slice, LSB nibble first.
// Optional zero/negative result flags when SUB_SEQ_FLAGS_EN is defined.
module sub_seq_ctrl
  import sub_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
`ifdef SUB_SEQ_FLAGS_EN
  output logic             out_zero,
  output logic             out_neg,
`endif
  output logic             out_borrow
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_width_check
    $error("sub_seq_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  sub_seq_state_t state_reg, state_next;

  logic [CNT_W-1:0]       cnt_reg;
  logic [WIDTH-1:0]       a_sr_reg;
  logic [WIDTH-1:0]       b_sr_reg;
  logic [WIDTH-NIB_W-1:0] res_sr_reg;
  logic                   bchain_reg;
  logic [WIDTH-1:0]       out_diff_reg;
  logic                   out_borrow_reg;

  logic [NIB_W-1:0] slice_dout;
  logic             slice_bout;
  logic [WIDTH-1:0] res_next;
  logic             last_nib;

  sub_4bit u_slice (
    .din1 (a_sr_reg[NIB_W-1:0]),
    .din2 (b_sr_reg[NIB_W-1:0]),
    .bin  (bchain_reg),
    .dout (slice_dout),
    .bout (slice_bout),
    .pg   (),
    .gg   ()
  );

  // Lower nibbles already produced plus the one coming out of the slice now
  assign res_next = {slice_dout, res_sr_reg};
  assign last_nib = (cnt_reg == CNT_W'(NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_RUN;
      end
      S_RUN: begin
        if (last_nib) state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      a_sr_reg       <= '0;
      b_sr_reg       <= '0;
      res_sr_reg     <= '0;
      bchain_reg     <= BIN_NO_BORROW;
      out_diff_reg   <= '0;
      out_borrow_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            a_sr_reg   <= in_a;
            b_sr_reg   <= in_b;
            bchain_reg <= BIN_NO_BORROW;
            cnt_reg    <= '0;
          end
        end
        S_RUN: begin
          a_sr_reg   <= a_sr_reg >> NIB_W;
          b_sr_reg   <= b_sr_reg >> NIB_W;
          res_sr_reg <= res_next[WIDTH-1:NIB_W];
          bchain_reg <= ~slice_bout;
          cnt_reg    <= cnt_reg + CNT_W'(1);
          if (last_nib) begin
            out_diff_reg   <= res_next;
            out_borrow_reg <= slice_bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_diff   = out_diff_reg;
  assign out_borrow = out_borrow_reg;

`ifdef SUB_SEQ_FLAGS_EN
  logic out_zero_reg;
  logic out_neg_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero_reg <= 1'b0;
      out_neg_reg  <= 1'b0;
    end else if (state_reg == S_RUN && last_nib) begin
      out_zero_reg <= (res_next == '0);
      out_neg_reg  <= res_next[WIDTH-1];
    end
  end

  assign out_zero = out_zero_reg;
  assign out_neg  = out_neg_reg;
`endif

endmodule
